// File: rtl/request_encoder.sv
// request_encoder: collects request pulses into a pending set and presents one index per cycle over ready/valid.
// Define REQUEST_ENCODER_ROUND_ROBIN_EN for round-robin arbitration; default is lowest-index priority.
module request_encoder #(
  parameter int ENCODE_WIDTH = 2,
  parameter int DECODE_WIDTH = 2**ENCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DECODE_WIDTH-1:0] req_in,
  output logic [ENCODE_WIDTH-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DECODE_WIDTH-1:0] pending,
  output logic [7:0]              merged_cnt
);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e                  state_q;
  logic [ENCODE_WIDTH-1:0] out_q, sel_p, sel_k;
  logic [DECODE_WIDTH-1:0] pending_q, pending_d, clear_mask, kept;
  logic [7:0]              merged_q, merged_d;
  logic                    hs;
  int                      merged_sum;

  function automatic logic [ENCODE_WIDTH-1:0] lowest(input logic [DECODE_WIDTH-1:0] v);
    lowest = '0;
    for (int i = DECODE_WIDTH - 1; i >= 0; i--) if (v[i]) lowest = ENCODE_WIDTH'(i);
  endfunction

`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
  logic [ENCODE_WIDTH-1:0] ptr_q, nptr;
  logic [DECODE_WIDTH-1:0] ge_p, ge_k;
  // On a handshake the next pick already uses the pointer past the index being accepted
  assign nptr = out_q == ENCODE_WIDTH'(DECODE_WIDTH - 1) ? '0 : out_q + 1'b1;
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      ge_p[i] = i >= int'(ptr_q);
      ge_k[i] = i >= int'(nptr);
    end
  end
  assign sel_p = |(pending_q & ge_p) ? lowest(pending_q & ge_p) : lowest(pending_q);
  assign sel_k = |(kept & ge_k) ? lowest(kept & ge_k) : lowest(kept);
`else
  assign sel_p = lowest(pending_q);
  assign sel_k = lowest(kept);
`endif

  assign hs         = state_q == HOLD && out_ready;
  assign clear_mask = hs ? DECODE_WIDTH'(1) << out_q : '0;
  assign kept       = pending_q & ~clear_mask;
  assign pending_d  = kept | req_in;
  assign merged_sum = int'(merged_q) + $countones(req_in & kept);
  assign merged_d   = merged_sum > 255 ? 8'hff : merged_sum[7:0];

  assign out        = out_q;
  assign out_valid  = state_q == HOLD;
  assign pending    = pending_q;
  assign merged_cnt = merged_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      pending_q <= '0;
      merged_q  <= '0;
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      merged_q  <= merged_d;
      if (state_q == IDLE) begin
        if (|pending_q) begin
          state_q <= HOLD;
          out_q   <= sel_p;
        end
      end else if (out_ready) begin
        if (|kept) out_q <= sel_k;
        else state_q <= IDLE;
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
        ptr_q <= nptr;
`endif
      end
    end
  end
endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder: directed vectors against a set-based reference model plus hand-computed literal checks.
module tb_request_encoder;
  localparam int EW = 2;
  localparam int DW = 4;

  logic          clk = 0;
  logic          rst_n = 1;
  logic [DW-1:0] req_in = '0;
  logic          out_ready = 0;
  logic [EW-1:0] out;
  logic          out_valid;
  logic [DW-1:0] pending;
  logic [7:0]    merged_cnt;

  int vectors = 0;
  int miscompares = 0;

  request_encoder #(.ENCODE_WIDTH(EW), .DECODE_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .pending(pending), .merged_cnt(merged_cnt)
  );

  always #5 clk = ~clk;

  // Reference: pending is a set of line numbers, output is the chosen member
  bit mp[DW];
  bit mval = 0;
  int mout = 0;
  int mmerged = 0;
  int mptr = 0;

  function automatic int choose(input bit v[DW], input int p);
    for (int k = 0; k < DW; k++) if (v[(p + k) % DW]) return (p + k) % DW;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hs;
    bit any_keep;
    bit any_p;
    bit keep[DW];
    if (!rst_n) begin
      for (int i = 0; i < DW; i++) mp[i] = 0;
      mval = 0; mout = 0; mmerged = 0; mptr = 0;
    end else begin
      hs = mval && out_ready;
      any_keep = 0;
      any_p = 0;
      for (int i = 0; i < DW; i++) begin
        keep[i] = mp[i] && !(hs && i == mout);
        any_keep |= keep[i];
        any_p |= mp[i];
        if (req_in[i] && keep[i] && mmerged < 255) mmerged++;
      end
      if (!mval) begin
        if (any_p) begin mval = 1; mout = choose(mp, mptr); end
      end else if (hs) begin
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
        mptr = (mout + 1) % DW;
`endif
        if (any_keep) mout = choose(keep, mptr);
        else mval = 0;
      end
      for (int i = 0; i < DW; i++) mp[i] = keep[i] || req_in[i];
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] exp_p;
    for (int i = 0; i < DW; i++) exp_p[i] = mp[i];
    vectors++;
    if (out_valid !== mval || (mval && out !== EW'(mout)) || pending !== exp_p || merged_cnt !== 8'(mmerged)) begin
      miscompares++;
      $display("FAIL model t=%0t: valid=%b out=%0d pending=%b merged=%0d, required valid=%b out=%0d pending=%b merged=%0d",
               $time, out_valid, out, pending, merged_cnt, mval, mout, exp_p, mmerged);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [DW-1:0] r, input logic y);
    req_in = r;
    out_ready = y;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] tbl[12] = '{5'b1_0110, 5'b0_1000, 5'b1_0001, 5'b1_1111, 5'b0_0000, 5'b1_0101,
                          5'b1_0000, 5'b0_1010, 5'b0_1010, 5'b1_0000, 5'b1_0100, 5'b1_0000};

  initial begin
    #1 rst_n = 0;
    #1;
    chk("reset_out", int'(out), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_merged", int'(merged_cnt), 0);
    step('0, 0);
    rst_n = 1;
    repeat (3) step('0, 0);
    chk("idle_valid", int'(out_valid), 0);

    step(4'b0100, 1);
    chk("single_pending", int'(pending), 4);
    chk("single_not_yet", int'(out_valid), 0);
    step('0, 1);
    chk("single_valid", int'(out_valid), 1);
    chk("single_out", int'(out), 2);
    step('0, 1);
    chk("single_done", int'(out_valid), 0);
    chk("single_clear", int'(pending), 0);

    step(4'b1011, 1);
    step('0, 1);
    chk("seq_out0", int'(out), 0);
    step('0, 1);
    chk("seq_out1", int'(out), 1);
    step('0, 1);
    chk("seq_out3", int'(out), 3);
    chk("seq_valid3", int'(out_valid), 1);
    step('0, 1);
    chk("seq_end", int'(out_valid), 0);

    step(4'b0011, 0);
    step('0, 0);
    for (int i = 0; i < 5; i++) begin
      step('0, 0);
      chk("stall_out", int'(out), 0);
      chk("stall_valid", int'(out_valid), 1);
    end
    step(4'b0001, 0);
    chk("merge_one", int'(merged_cnt), 1);
    repeat (300) step(4'b0001, 0);
    chk("merge_sat", int'(merged_cnt), 255);
    step(4'b0001, 1);
    chk("set_wins_pending", int'(pending), 3);
    chk("set_wins_out", int'(out), 1);
    chk("set_wins_merged", int'(merged_cnt), 255);
    step('0, 1);
    chk("drain_out", int'(out), 0);
    step('0, 1);
    chk("drain_end", int'(out_valid), 0);

    step(4'b0001, 1);
    step('0, 1);
    step('0, 1);
    step(4'b1001, 1);
    step('0, 1);
`ifdef REQUEST_ENCODER_ROUND_ROBIN_EN
    chk("arb_first", int'(out), 3);
    step('0, 1);
    chk("arb_second", int'(out), 0);
`else
    chk("arb_first", int'(out), 0);
    step('0, 1);
    chk("arb_second", int'(out), 3);
`endif
    step('0, 1);

    step(4'b1110, 0);
    step('0, 0);
    chk("pre_reset_pending", int'(pending), 14);
    #2 rst_n = 0;
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_pending", int'(pending), 0);
    step('0, 1);
    rst_n = 1;
    repeat (4) step('0, 1);
    chk("post_reset_valid", int'(out_valid), 0);

    for (int i = 0; i < 12; i++) step(tbl[i][3:0], tbl[i][4]);
    repeat (6) step('0, 1);
    chk("final_idle", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
